interp_ce_scheduler: RTL and testbench

- Controller for the 7-stage interpolating chain (two half-band stages, inverse-sinc, four CICs). Each stage interpolates by 2.
- Generates all per-stage clock enables from one master tick, replacing the daisy-chained ce wiring between stages.
- Sequences run/stop of the chain, requests input samples from the upstream source with a valid/ready handshake, and zero-stuffs on underrun and during drain.
- Sits between the sample source and the filter chain; stage_ce[k] drives the clk_enable of the stage k positions from the output end.

---
 rtl/interp_ce_scheduler_pkg.sv | 19 +
 rtl/interp_ce_scheduler_phase_counter.sv | 37 +++
 rtl/interp_ce_scheduler.sv | 86 ++++++++
 tb/tb_interp_ce_scheduler.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/interp_ce_scheduler_pkg.sv
// Shared types and constants for the interpolating-chain clock-enable scheduler.
package interp_ce_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int NUM_STAGES_DEF = 7;
  localparam int DATA_W_DEF     = 16;

  // All-ones mask covering the k least significant bits.
  function automatic logic [31:0] low_mask(input int k);
    if (k >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << k) - 32'd1;
  endfunction

endpackage

// File: rtl/interp_ce_scheduler_phase_counter.sv
// Free-running phase counter and per-stage enable decode; stage k fires every 2^k ticks.
module interp_phase_counter
  import interp_ce_scheduler_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick_i,
  input  logic                  clear_i,
  output logic [NUM_STAGES-1:0] stage_ce_o
);

  localparam int CW = (NUM_STAGES > 1) ? NUM_STAGES - 1 : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)     cnt_d = '0;
    else if (tick_i) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign stage_ce_o[0] = tick_i;

  // Stage k sees its enable when the k low counter bits are all ones.
  for (genvar k = 1; k < NUM_STAGES; k++) begin : g_ce
    localparam logic [31:0] MASK = low_mask(k);
    assign stage_ce_o[k] = tick_i && ((cnt_q & MASK[CW-1:0]) == MASK[CW-1:0]);
  end

endmodule

// File: rtl/interp_ce_scheduler.sv
// Run/stop sequencer, sample request handshake and underrun tracking for the x2 interpolating chain.
module interp_ce_scheduler
  import interp_ce_scheduler_pkg::*;
#(
  parameter int NUM_STAGES  = NUM_STAGES_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DRAIN_TICKS = 8,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_enable,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] stage_data,
  output logic [NUM_STAGES-1:0]    stage_ce,
  output logic                     busy,
  output logic [CNT_W-1:0]         underrun_count
);

  localparam int DCW = $clog2(DRAIN_TICKS + 1);

  state_e                   state_q, state_d;
  logic                     busy_q;
  logic [DCW-1:0]           drain_cnt_q;
  logic signed [DATA_W-1:0] stage_data_q;
  logic [CNT_W-1:0]         underrun_q;
  logic                     tick, top_ce, clear, drain_done;

  assign tick = clk_enable && (state_q != ST_IDLE);

  interp_phase_counter #(.NUM_STAGES(NUM_STAGES)) u_phase (
    .clk       (clk),
    .reset     (reset),
    .tick_i    (tick),
    .clear_i   (clear),
    .stage_ce_o(stage_ce)
  );

  assign top_ce     = stage_ce[NUM_STAGES-1];
  assign in_ready   = (state_q == ST_RUN) && top_ce;
  assign drain_done = (state_q == ST_DRAIN) && top_ce && (drain_cnt_q == DCW'(DRAIN_TICKS - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start && !stop) state_d = ST_RUN;
      ST_RUN:   if (stop)           state_d = ST_DRAIN;
      ST_DRAIN: if (drain_done)     state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  // Phase restarts on entering RUN and on returning to IDLE; RUN->DRAIN keeps it.
  assign clear = ((state_q == ST_IDLE) && (state_d == ST_RUN)) ||
                 ((state_q != ST_IDLE) && (state_d == ST_IDLE));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      drain_cnt_q  <= '0;
      stage_data_q <= '0;
      underrun_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      if ((state_q == ST_DRAIN) && top_ce)
        drain_cnt_q <= drain_done ? '0 : drain_cnt_q + DCW'(1);
      if (in_ready) begin
        stage_data_q <= in_valid ? in_data : '0;
        if (!in_valid && (underrun_q != '1)) underrun_q <= underrun_q + CNT_W'(1);
      end else if ((state_q == ST_DRAIN) && top_ce) begin
        stage_data_q <= '0;
      end
    end
  end

  assign busy           = busy_q;
  assign stage_data     = stage_data_q;
  assign underrun_count = underrun_q;

endmodule

// File: tb/tb_interp_ce_scheduler.sv
// Bench for interp_ce_scheduler: table vectors, directed sequences and a randomized run against a rate-based model.
module tb_interp_ce_scheduler;

  localparam int NS = 7;
  localparam int DW = 16;
  localparam int DT = 8;
  localparam int CW = 4;

  logic                 clk = 1'b0;
  logic                 reset, clk_enable, start, stop, in_valid;
  logic signed [DW-1:0] in_data;
  logic                 in_ready;
  logic signed [DW-1:0] stage_data;
  logic [NS-1:0]        stage_ce;
  logic                 busy;
  logic [CW-1:0]        underrun_count;

  interp_ce_scheduler #(.NUM_STAGES(NS), .DATA_W(DW), .DRAIN_TICKS(DT), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .clk_enable    (clk_enable),
    .start         (start),
    .stop          (stop),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .stage_data    (stage_data),
    .stage_ce      (stage_ce),
    .busy          (busy),
    .underrun_count(underrun_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: mode 0 idle / 1 run / 2 drain; ticks counted since the phase was last restarted.
  int                   m_mode = 0, m_ticks = 0, m_drain = 0, m_under = 0;
  logic signed [DW-1:0] m_data = '0;
  logic                 m_busy = 1'b0;
  logic [NS-1:0]        e_ce;
  logic                 e_rdy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_comb();
    int t;
    logic tk;
    t  = m_ticks + 1;
    tk = clk_enable && (m_mode != 0);
    for (int k = 0; k < NS; k++) e_ce[k] = tk && ((t % (1 << k)) == 0);
    e_rdy = (m_mode == 1) && e_ce[NS-1];
  endtask

  task automatic model_edge();
    logic tk, top;
    tk  = clk_enable && (m_mode != 0);
    top = e_ce[NS-1];
    if (reset) begin
      m_mode = 0; m_ticks = 0; m_drain = 0; m_under = 0; m_data = '0;
    end else begin
      if (e_rdy) begin
        if (in_valid) m_data = in_data;
        else begin
          m_data = '0;
          if (m_under < (1 << CW) - 1) m_under++;
        end
      end
      if (tk) m_ticks++;
      case (m_mode)
        0: if (start && !stop) begin m_mode = 1; m_ticks = 0; end
        1: if (stop) m_mode = 2;
        default: if (top) begin
          m_data = '0;
          m_drain++;
          if (m_drain == DT) begin m_mode = 0; m_drain = 0; m_ticks = 0; end
        end
      endcase
    end
    m_busy = (m_mode != 0);
  endtask

  task automatic sample(input bit cmp);
    @(negedge clk);
    model_comb();
    if (cmp) begin
      check("stage_ce", 64'(stage_ce), 64'(e_ce));
      check("in_ready", 64'(in_ready), 64'(e_rdy));
      check("stage_data", 64'(stage_data), 64'(m_data));
      check("busy", 64'(busy), 64'(m_busy));
      check("underrun_count", 64'(underrun_count), 64'(m_under));
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step();
    sample(1'b1);
    advance();
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_stage_ce"}, 64'(stage_ce), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_stage_data"}, 64'(stage_data), 64'd0);
    check({tag, "_underrun"}, 64'(underrun_count), 64'd0);
  endtask

  typedef struct {
    logic          rst, ce, st, sp;
    logic [NS-1:0] exp_ce;
    logic          exp_busy;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int  first_top, n_top, n_ce0, n_ce1, n_rdy, n_req, n_bad, cyc;
    bit  acc;

    tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 7'b0000000, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 7'b0000000, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 7'b0000000, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 7'b0000001, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 7'b0000011, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 7'b0000001, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 7'b0000111, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 7'b0000001, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 7'b0000000, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 7'b0000000, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 7'b0000000, 1'b0};

    reset = 1'b1; clk_enable = 1'b1; start = 1'b0; stop = 1'b0;
    in_valid = 1'b0; in_data = '0;
    sample(1'b0);
    advance();
    step();
    check_cleared("reset");
    reset = 1'b0;

    // Table vectors: start/stop combinations in IDLE, first enables, clk_enable gap, reset in RUN.
    for (int i = 0; i < 12; i++) begin
      reset = tbl[i].rst; clk_enable = tbl[i].ce; start = tbl[i].st; stop = tbl[i].sp;
      sample(1'b1);
      check($sformatf("tbl%0d_stage_ce", i), 64'(stage_ce), 64'(tbl[i].exp_ce));
      check($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].exp_busy));
      advance();
    end
    reset = 1'b0; start = 1'b0; stop = 1'b0; clk_enable = 1'b1;

    // Enable rates and ramp acceptance.
    in_valid = 1'b1; in_data = 16'sd1;
    start = 1'b1; step(); start = 1'b0;
    first_top = -1; n_top = 0; n_ce1 = 0;
    for (int i = 0; i < 320; i++) begin
      sample(1'b1);
      if (stage_ce[NS-1]) begin
        if (first_top < 0) first_top = i;
        n_top++;
      end
      if (i < 64 && stage_ce[1]) n_ce1++;
      acc = in_ready && in_valid;
      advance();
      if (acc) in_data = in_data + 16'sd1;
    end
    check("first_top_tick", 64'(first_top), 64'd63);
    check("top_pulses", 64'(n_top), 64'd5);
    check("ce1_rate", 64'(n_ce1), 64'd32);
    check("ramp_data", 64'(stage_data), 64'd5);
    check("ramp_no_underrun", 64'(underrun_count), 64'd0);

    // Three consecutive underruns, then saturation.
    in_valid = 1'b0; n_req = 0; cyc = 0;
    while (n_req < 3 && cyc < 1000) begin
      sample(1'b1);
      if (in_ready) n_req++;
      advance(); cyc++;
    end
    check("underrun3_data", 64'(stage_data), 64'd0);
    check("underrun3_count", 64'(underrun_count), 64'd3);
    n_req = 0; cyc = 0;
    while (n_req < 14 && cyc < 2000) begin
      sample(1'b1);
      if (in_ready) n_req++;
      advance(); cyc++;
    end
    check("underrun_saturated", 64'(underrun_count), 64'd15);
    in_valid = 1'b1; in_data = -16'sd1234; n_req = 0; cyc = 0;
    while (n_req < 1 && cyc < 200) begin
      sample(1'b1);
      if (in_ready) n_req++;
      advance(); cyc++;
    end
    check("accept_after_underrun", 64'(stage_data), 64'(-16'sd1234));
    check("underrun_held", 64'(underrun_count), 64'd15);

    // clk_enable alternating: enables at half rate, no request while low.
    n_top = 0; n_ce0 = 0; n_bad = 0;
    for (int i = 0; i < 256; i++) begin
      clk_enable = (i % 2 == 0);
      sample(1'b1);
      if (stage_ce[NS-1]) n_top++;
      if (stage_ce[0]) n_ce0++;
      if (!clk_enable && (in_ready || stage_ce != '0)) n_bad++;
      advance();
    end
    clk_enable = 1'b1;
    check("half_rate_ce0", 64'(n_ce0), 64'd128);
    check("half_rate_top", 64'(n_top), 64'd2);
    check("no_enable_while_low", 64'(n_bad), 64'd0);

    // Stop: drain of DT top enables, start ignored mid-drain.
    stop = 1'b1; step(); stop = 1'b0;
    n_top = 0; n_rdy = 0; cyc = 0;
    while (cyc < 64 * (DT + 4)) begin
      start = (cyc == 100);
      sample(1'b1);
      if (!busy) break;
      if (stage_ce[NS-1]) n_top++;
      if (in_ready) n_rdy++;
      advance();
      if (n_top == 1) check("drain_zero_data", 64'(stage_data), 64'd0);
      cyc++;
    end
    advance();
    start = 1'b0;
    check("drain_top_pulses", 64'(n_top), 64'd8);
    check("drain_no_ready", 64'(n_rdy), 64'd0);
    for (int i = 0; i < 4; i++) step();
    check("idle_after_drain", 64'(busy), 64'd0);

    // Reset mid-RUN and mid-DRAIN.
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 70; i++) step();
    reset = 1'b1; step(); reset = 1'b0;
    check_cleared("rst_run");
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 100; i++) step();
    stop = 1'b1; step(); stop = 1'b0;
    for (int i = 0; i < 50; i++) step();
    reset = 1'b1; step(); reset = 1'b0;
    check_cleared("rst_drain");

    // Randomized traffic against the model.
    for (int i = 0; i < 6000; i++) begin
      clk_enable = ($urandom_range(0, 3) != 0);
      start      = ($urandom_range(0, 39) == 0);
      stop       = ($urandom_range(0, 299) == 0);
      in_valid   = ($urandom_range(0, 9) < 7);
      in_data    = DW'($urandom);
      reset      = ($urandom_range(0, 1999) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
